// File: rtl/conv_ctrl_pkg.sv
// Shared types and inst bit map for the conv_ctrl sequencer.
// Holds the FSM state enum, inst bit positions and the idle inst word.
package conv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_ARST, S_WL0, S_WLD, S_WGAP,
    S_AWR, S_AGAP, S_EXEC, S_EGAP,
    S_OPRE, S_OWR, S_OEND, S_DRAIN, S_DONE
  } state_t;

  localparam int ACC_B  = 33;
  localparam int CENP_B = 32;
  localparam int WENP_B = 31;
  localparam int AP_LO  = 20;
  localparam int CENX_B = 19;
  localparam int WENX_B = 18;
  localparam int AX_LO  = 7;
  localparam int OFRD_B = 6;
  localparam int IFWR_B = 5;
  localparam int IFRD_B = 4;
  localparam int L0RD_B = 3;
  localparam int L0WR_B = 2;
  localparam int EXEC_B = 1;
  localparam int LOAD_B = 0;

  localparam logic [33:0] INST_IDLE =
    (34'd1 << CENP_B) | (34'd1 << WENP_B) |
    (34'd1 << CENX_B) | (34'd1 << WENX_B);

endpackage

// File: rtl/conv_ctrl_if.sv
// Output bus of the convolution sequencer towards dual_core.
// master: sequencer side (start in, inst/tile/sel/mode/relu/arr_rst/busy/done out).
interface conv_ctrl_if;
  logic        start;
  logic [33:0] inst;
  logic [1:0]  tile;
  logic        sel;
  logic        mode;
  logic        relu;
  logic        arr_rst;
  logic        busy;
  logic        done;

  modport master (
    input  start,
    output inst, tile, sel, mode, relu,
    output arr_rst, busy, done
  );

  modport slave (
    output start,
    input  inst, tile, sel, mode, relu,
    input  arr_rst, busy, done
  );
endinterface

// File: rtl/conv_ctrl_pmem_ofs.sv
// kij -> PMEM start address, -(kij%ki_sz + (kij/ki_sz)*nij_sz) mod 2^11.
// Ports: kij (4b) in, ofs (11b) out; purely combinational.
module conv_ctrl_pmem_ofs #(
  parameter int ki_sz  = 3,
  parameter int nij_sz = 6
) (
  input  logic [3:0]  kij,
  output logic [10:0] ofs
);
  logic [10:0] pos;

  assign pos = 11'(kij % 4'(ki_sz))
             + 11'(kij / 4'(ki_sz)) * 11'(nij_sz);
  // The negative start is intentional: it shifts the
  // output window so each kij lands on its psum rows.
  assign ofs = -pos;
endmodule

// File: rtl/conv_ctrl.sv
// Sequencer for one 3x3 conv pass: walks all kij, drives inst/tile/sel/relu.
// Ports: clk, reset (sync, active-low), bus (conv_ctrl_if.master). Option: CONV_CTRL_RELU_EN.
module conv_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int col     = 8,
  parameter int row     = 8,
  parameter int len_nij = 36,
  parameter int nij_sz  = 6,
  parameter int len_kij = 9,
  parameter int ki_sz   = 3,
  parameter int htiles  = 2,
  parameter logic [10:0] W_BASE = 11'h400
) (
  input logic        clk,
  input logic        reset,
  conv_ctrl_if.master bus
);
  localparam logic [5:0] ARST_LAST = 6'd2;
  localparam logic [5:0] WLD_LAST  = 6'(row + 2 * col - 1);
  localparam logic [5:0] LOAD_N    = 6'(2 * col);
  localparam logic [5:0] WR_N      = 6'(2 * col - 1);
  localparam logic [5:0] AWR_LAST  = 6'(len_nij - 1);
  localparam logic [5:0] EXEC_LAST = 6'(len_nij + 2 * col - 1);
  localparam logic [5:0] EXEC_N    = 6'(len_nij);
  localparam logic [5:0] DRN_LAST  = 6'd1;
  localparam logic [3:0] KIJ_LAST  = 4'(len_kij - 1);
  localparam logic       TILE_LAST = 1'(htiles - 1);

  state_t      state, nstate;
  logic [3:0]  kij, nkij;
  logic        tsel, ntsel;
  logic [5:0]  t, nt;

  logic [33:0] inst_q, inst_d;
  logic [1:0]  tile_q, tile_d;
  logic        sel_q, sel_d;
  logic        relu_q, relu_d;
  logic        arst_q, arst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [10:0] ofs;
  logic [10:0] wbase;

  conv_ctrl_pmem_ofs #(
    .ki_sz (ki_sz),
    .nij_sz(nij_sz)
  ) u_ofs (
    .kij(nkij),
    .ofs(ofs)
  );

  assign wbase = W_BASE
    + (11'(nkij) * 11'(htiles) + 11'(ntsel)) * 11'(2 * col);

  always_comb begin
    nstate = state;
    nkij   = kij;
    ntsel  = tsel;
    nt     = t + 6'd1;
    unique case (state)
      S_IDLE: begin
        nt = '0;
        if (bus.start) begin
          nstate = S_ARST;
          nkij   = '0;
          ntsel  = 1'b0;
        end
      end
      S_ARST: if (t == ARST_LAST) begin
        nstate = S_WL0;
        nt     = '0;
      end
      S_WL0: begin
        nstate = S_WLD;
        nt     = '0;
      end
      S_WLD: if (t == WLD_LAST) begin
        nstate = S_WGAP;
        nt     = '0;
      end
      S_WGAP: begin
        nt = '0;
        if (tsel == TILE_LAST) begin
          nstate = S_AWR;
        end else begin
          nstate = S_WL0;
          ntsel  = tsel + 1'b1;
        end
      end
      S_AWR: if (t == AWR_LAST) begin
        nstate = S_AGAP;
        nt     = '0;
      end
      S_AGAP: begin
        nstate = S_EXEC;
        nt     = '0;
      end
      S_EXEC: if (t == EXEC_LAST) begin
        nstate = S_EGAP;
        nt     = '0;
      end
      S_EGAP: begin
        nstate = S_OPRE;
        nt     = '0;
      end
      S_OPRE: begin
        nstate = S_OWR;
        nt     = '0;
      end
      S_OWR: if (t == AWR_LAST) begin
        nstate = S_OEND;
        nt     = '0;
      end
      S_OEND: begin
        nstate = S_DRAIN;
        nt     = '0;
      end
      S_DRAIN: if (t == DRN_LAST) begin
        nt = '0;
        if (kij < KIJ_LAST) begin
          nstate = S_ARST;
          nkij   = kij + 4'd1;
          ntsel  = 1'b0;
        end else begin
          nstate = S_DONE;
        end
      end
      S_DONE: begin
        nstate = S_IDLE;
        nt     = '0;
      end
      default: begin
        nstate = S_IDLE;
        nt     = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that the
  // registered bus lines up with the state it describes.
  always_comb begin
    inst_d = INST_IDLE;
    tile_d = 2'b01;
    sel_d  = 1'b0;
    relu_d = 1'b0;
    arst_d = 1'b0;
    busy_d = !(nstate inside {S_IDLE, S_DONE});
    done_d = (nstate == S_DONE);
    unique case (nstate)
      S_ARST: arst_d = (nt == '0);
      S_WL0: begin
        tile_d = 2'b01 << ntsel;
        inst_d[L0WR_B] = 1'b1;
        inst_d[CENX_B] = 1'b0;
        inst_d[AX_LO +: 11] = wbase;
      end
      S_WLD: begin
        tile_d = 2'b01 << ntsel;
        inst_d[L0RD_B] = 1'b1;
        inst_d[LOAD_B] = (nt < LOAD_N);
        inst_d[L0WR_B] = (nt < WR_N);
        inst_d[CENX_B] = !(nt < WR_N);
        inst_d[AX_LO +: 11] = wbase + 11'(nt) + 11'd1;
      end
      S_WGAP: tile_d = 2'b01 << ntsel;
      S_AWR: begin
        tile_d = 2'b11;
        inst_d[L0WR_B] = 1'b1;
        inst_d[CENX_B] = 1'b0;
        inst_d[AX_LO +: 11] = 11'(nt);
      end
      S_EXEC: begin
        tile_d = 2'b11;
        inst_d[L0RD_B] = 1'b1;
        inst_d[EXEC_B] = (nt < EXEC_N);
      end
      S_OPRE, S_OWR: begin
        tile_d = 2'b11;
        sel_d  = nkij[0];
        inst_d[OFRD_B] = 1'b1;
        inst_d[ACC_B]  = (nkij != '0);
        if (nstate == S_OWR) begin
          inst_d[CENP_B] = 1'b0;
          inst_d[WENP_B] = 1'b0;
          inst_d[AP_LO +: 11] = ofs + 11'(nt);
        end else begin
          inst_d[AP_LO +: 11] = ofs;
        end
      end
      S_AGAP, S_EGAP, S_OEND, S_DRAIN: tile_d = 2'b11;
      default: ;
    endcase
    inst_d[WENX_B] = 1'b1;
    inst_d[IFWR_B] = 1'b0;
    inst_d[IFRD_B] = 1'b0;
`ifdef CONV_CTRL_RELU_EN
    relu_d = (nstate inside {S_OPRE, S_OWR, S_OEND})
          && (nkij == KIJ_LAST);
`else
    relu_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S_IDLE;
      kij    <= '0;
      tsel   <= 1'b0;
      t      <= '0;
      inst_q <= INST_IDLE;
      tile_q <= 2'b01;
      sel_q  <= 1'b0;
      relu_q <= 1'b0;
      arst_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= nstate;
      kij    <= nkij;
      tsel   <= ntsel;
      t      <= nt;
      inst_q <= inst_d;
      tile_q <= tile_d;
      sel_q  <= sel_d;
      relu_q <= relu_d;
      arst_q <= arst_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.inst    = inst_q;
  assign bus.tile    = tile_q;
  assign bus.sel     = sel_q;
  assign bus.mode    = 1'b0;
  assign bus.relu    = relu_q;
  assign bus.arr_rst = arst_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_conv_ctrl.sv
// Self-checking bench for conv_ctrl: timeline model plus directed pins.
// Drives start/reset through conv_ctrl_if; honours CONV_CTRL_RELU_EN.
module tb_conv_ctrl;
  localparam logic [33:0] IDLE_W =
    34'b0_1_1_00000000000_1_1_00000000000_0000000;
  localparam int KLEN = 185;
  localparam int PASS = 9 * KLEN;

  typedef struct packed {
    logic [33:0] inst;
    logic [1:0]  tile;
    logic        sel;
    logic        mode;
    logic        relu;
    logic        arr_rst;
    logic        busy;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  conv_ctrl_if bus();

  conv_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [33:0] act,
                       input logic [33:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Expected outputs for cycle c of a pass (c=1 first busy
  // cycle, c=PASS+1 the done cycle, 0 idle).
  function automatic exp_t model(int c, bit in_rst);
    exp_t e;
    int k, r, w, j, s, base, pofs;
    e = '0;
    e.inst = IDLE_W;
    e.tile = 2'b01;
    e.arr_rst = in_rst;
    if (c == PASS + 1) begin
      e.done = 1'b1;
    end else if (c >= 1) begin
      e.busy = 1'b1;
      k = (c - 1) / KLEN;
      r = (c - 1) % KLEN;
      if (r == 0) e.arr_rst = 1'b1;
      if (r >= 3 && r < 55) begin
        w = r - 3;
        j = w / 26;
        s = w % 26;
        e.tile = (j == 0) ? 2'b01 : 2'b10;
        base = 'h400 + (k * 2 + j) * 16;
        if (s <= 24) e.inst[17:7] = 11'(base + s);
        if (s <= 15) begin
          e.inst[2] = 1'b1;
          e.inst[19] = 1'b0;
        end
        if (s >= 1 && s <= 24) e.inst[3] = 1'b1;
        if (s >= 1 && s <= 16) e.inst[0] = 1'b1;
      end else if (r >= 55) begin
        e.tile = 2'b11;
        if (r <= 90) begin
          e.inst[2] = 1'b1;
          e.inst[19] = 1'b0;
          e.inst[17:7] = 11'(r - 55);
        end
        if (r >= 92 && r <= 143) begin
          e.inst[3] = 1'b1;
          e.inst[1] = (r < 128);
        end
        if (r >= 145 && r <= 181) begin
          pofs = -((k % 3) + (k / 3) * 6);
          e.inst[6] = 1'b1;
          e.inst[33] = (k > 0);
          e.sel = k[0];
          if (r >= 146) begin
            pofs = pofs + (r - 146);
            e.inst[32] = 1'b0;
            e.inst[31] = 1'b0;
          end
          e.inst[30:20] = 11'(pofs);
        end
`ifdef CONV_CTRL_RELU_EN
        if (k == 8 && r >= 145 && r <= 182) e.relu = 1'b1;
`endif
      end
    end
    return e;
  endfunction

  int mc = 0;
  bit m_rst = 1'b1;
  bit armed = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      mc = 0;
      m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      if (mc == 0) begin
        if (bus.start) mc = 1;
      end else if (mc == PASS + 1) begin
        mc = 0;
      end else begin
        mc++;
      end
    end
    armed = 1'b1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (armed) begin
      e = model(mc, m_rst);
      check("inst", bus.inst, e.inst);
      check("flags",
        34'({bus.tile, bus.sel, bus.mode, bus.relu,
             bus.arr_rst, bus.busy, bus.done}),
        34'({e.tile, e.sel, e.mode, e.relu,
             e.arr_rst, e.busy, e.done}));
    end
  end

  initial begin
    int n, done_n, nrst, nbusy, nload, nwr, nrelu;
    reset = 1'b0;
    bus.start = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("rst_inst", bus.inst, IDLE_W);
      check("rst_tile", 34'(bus.tile), 34'h1);
      check("rst_arr_rst", 34'(bus.arr_rst), 34'h1);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_arr_rst", 34'(bus.arr_rst), 34'h0);
    check("idle_busy", 34'(bus.busy), 34'h0);

    reset = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    check("rst_wins_busy", 34'(bus.busy), 34'h0);
    bus.start = 1'b0;
    reset = 1'b1;
    @(negedge clk);

    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (n = 1; n < 660; n++) @(negedge clk);
    check("exec_k3", 34'(bus.inst[1]), 34'h1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_inst", bus.inst, IDLE_W);
    check("abort_busy", 34'(bus.busy), 34'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    done_n = 0;
    nrst = 0;
    nbusy = 0;
    nload = 0;
    nwr = 0;
    nrelu = 0;
    while (n <= PASS + 40 && done_n == 0) begin
      if (bus.done) done_n = n;
      if (bus.arr_rst) nrst++;
      if (bus.busy) nbusy++;
      if (bus.relu) nrelu++;
      if (n >= 30 && n <= 55) begin
        if (bus.inst[0]) nload++;
        if (bus.inst[2]) nwr++;
      end
      if (n == 4) check("k0t0_ax", 34'(bus.inst[17:7]), 34'h400);
      if (n == 30) check("k0t1_ax", 34'(bus.inst[17:7]), 34'h410);
      if (n == 146) begin
        check("k0_acc", 34'(bus.inst[33]), 34'h0);
        check("k0_ap", 34'(bus.inst[30:20]), 34'h0);
      end
      if (n == 886) begin
        check("k4_ap", 34'(bus.inst[30:20]), 34'h7F9);
        check("k4_acc", 34'(bus.inst[33]), 34'h1);
        check("k4_sel", 34'(bus.sel), 34'h0);
      end
      if (n == 500) bus.start = 1'b1;
      if (n == 501) bus.start = 1'b0;
      @(negedge clk);
      n++;
    end
    check("done_at", 34'(done_n), 34'd1666);
    check("arr_rst_n", 34'(nrst), 34'd9);
    check("busy_n", 34'(nbusy), 34'd1665);
    check("load_n", 34'(nload), 34'd16);
    check("l0_wr_n", 34'(nwr), 34'd16);
`ifdef CONV_CTRL_RELU_EN
    check("relu_n", 34'(nrelu), 34'd38);
`else
    check("relu_n", 34'(nrelu), 34'd0);
`endif
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
